// File: rtl/pc_defs_pkg.sv
// Shared datapath definitions: register-file geometry and the clear/run state encoding.
// Decode and writeback use the same constants so that their widths agree with the register file.
package pc_defs_pkg;

  localparam int REG_DATA_W    = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int REG_ZERO_ADDR = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of register-file read/write ports shared by decode (reads) and writeback (writes).
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 3
);

  // Handshake: we0/we1 are single-cycle qualifiers sampled on posedge clk. There is no
  // ready; a write is accepted only while init_done=1 and is otherwise silently dropped.
  // Reads have no valid/ready and are purely combinational from raddr.
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic                    we0;
  logic [ADDR_W-1:0]       waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    we1;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic                    init_done;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  rdata, init_done
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
    output rdata, init_done
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry writing zero, then holds RUN and raises init_done.
module regfile_clear_fsm
  import pc_defs_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done,
  output rf_state_e         state
);

  // One spare bit so the counter never wraps back to entry 0 after the last entry.
  localparam logic [ADDR_W:0] LAST_ENTRY = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  rf_state_e       state_q, state_d;
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
  logic            init_done_q, init_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RF_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    clr_addr    = clr_cnt_q[ADDR_W-1:0];
    case (state_q)
      RF_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == LAST_ENTRY) begin
          state_d     = RF_RUN;
          init_done_d = 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  assign init_done = init_done_q;
  assign state     = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised write ports,
// optional zero register and write-to-read bypass, hardware clear after reset.
module regfile_mp
  import pc_defs_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf,
  output rf_state_e    dbg_state
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              init_done;
  rf_state_e         state;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done),
    .state     (state)
  );

  assign rf.init_done = init_done;
  assign dbg_state    = state;

  logic run;
  logic w0_ok;
  logic w1_ok;

  // Port 1 wins a same-address collision outright; port 0 is dropped, never merged.
  always_comb begin
    run   = (state == RF_RUN);
    w1_ok = run && rf.we1 && !((ZERO_REG != 0) && (rf.waddr1 == ZERO_ADDR));
    w0_ok = run && rf.we0 && !((ZERO_REG != 0) && (rf.waddr0 == ZERO_ADDR))
                          && !(rf.we1 && (rf.waddr0 == rf.waddr1));
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (w1_ok) mem_q[rf.waddr1] <= rf.wdata1;
      if (w0_ok) mem_q[rf.waddr0] <= rf.wdata0;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = rf.raddr[i*ADDR_W +: ADDR_W];

    // Zero-register rule is checked before bypass so address 0 can never leak write data.
    always_comb begin
      rd = mem_q[ra];
      if (!run) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == ZERO_ADDR)) begin
        rd = '0;
      end else if ((BYPASS != 0) && w1_ok && (rf.waddr1 == ra)) begin
        rd = rf.wdata1;
      end else if ((BYPASS != 0) && w0_ok && (rf.waddr0 == ra)) begin
        rd = rf.wdata0;
      end
    end

    assign rf.rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (32x32, 3 reads, zero reg, bypass) and
// instance B (8x32, 4 reads, no zero reg, no bypass) driven side by side.
module tb_regfile_mp;
  import pc_defs_pkg::*;

  localparam int DW   = 32;
  localparam int AW_A = 5;
  localparam int NR_A = 3;
  localparam int AW_B = 3;
  localparam int NR_B = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW_A), .NREAD(NR_A)) rf_a ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW_B), .NREAD(NR_B)) rf_b ();
  rf_state_e state_a;
  rf_state_e state_b;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW_A), .NREAD(NR_A), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rf(rf_a.slave), .dbg_state(state_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW_B), .NREAD(NR_B), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rf(rf_b.slave), .dbg_state(state_b)
  );

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_a [32];
  logic [DW-1:0] model_b [8];
  logic          a_run = 1'b0;
  logic          b_run = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, got %h", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s got %h expected %h", tag, got, e);
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_a(input logic [AW_A-1:0] ad);
    if (!a_run || ad == '0) return '0;
    if (rf_a.we1 && rf_a.waddr1 == ad) return rf_a.wdata1;
    if (rf_a.we0 && rf_a.waddr0 == ad) return rf_a.wdata0;
    return model_a[ad];
  endfunction

  function automatic logic [DW-1:0] exp_b(input logic [AW_B-1:0] ad);
    if (!b_run) return '0;
    return model_b[ad];
  endfunction

  task automatic commit_models();
    if (a_run) begin
      if (rf_a.we1 && rf_a.waddr1 != '0) model_a[rf_a.waddr1] = rf_a.wdata1;
      if (rf_a.we0 && rf_a.waddr0 != '0 && !(rf_a.we1 && rf_a.waddr0 == rf_a.waddr1))
        model_a[rf_a.waddr0] = rf_a.wdata0;
    end
    if (b_run) begin
      if (rf_b.we1) model_b[rf_b.waddr1] = rf_b.wdata1;
      if (rf_b.we0 && !(rf_b.we1 && rf_b.waddr0 == rf_b.waddr1))
        model_b[rf_b.waddr0] = rf_b.wdata0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic w0, input logic [AW_A-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW_A-1:0] a1, input logic [DW-1:0] d1);
    rf_a.we0 = w0; rf_a.waddr0 = a0; rf_a.wdata0 = d0;
    rf_a.we1 = w1; rf_a.waddr1 = a1; rf_a.wdata1 = d1;
  endtask

  task automatic drive_b(input logic w0, input logic [AW_B-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW_B-1:0] a1, input logic [DW-1:0] d1);
    rf_b.we0 = w0; rf_b.waddr0 = a0; rf_b.wdata0 = d0;
    rf_b.we1 = w1; rf_b.waddr1 = a1; rf_b.wdata1 = d1;
  endtask

  task automatic idle();
    drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    drive_b(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic set_ra_a(input int p, input logic [AW_A-1:0] ad);
    rf_a.raddr[p*AW_A +: AW_A] = ad;
  endtask

  task automatic set_ra_b(input int p, input logic [AW_B-1:0] ad);
    rf_b.raddr[p*AW_B +: AW_B] = ad;
  endtask

  // Compare every read port of both instances against the model for the current inputs.
  task automatic check_all(input string tag);
    #2;
    for (int p = 0; p < NR_A; p++) begin
      exp_q.push_back(exp_a(rf_a.raddr[p*AW_A +: AW_A]));
      check($sformatf("%s_a%0d", tag, p), rf_a.rdata[p*DW +: DW]);
    end
    for (int p = 0; p < NR_B; p++) begin
      exp_q.push_back(exp_b(rf_b.raddr[p*AW_B +: AW_B]));
      check($sformatf("%s_b%0d", tag, p), rf_b.rdata[p*DW +: DW]);
    end
  endtask

  task automatic tick();
    commit_models();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts posedges from the current point until each init_done rises; bounded at 100 cycles.
  task automatic wait_init(input string tag);
    int cyc = 0;
    int da  = 0;
    int db  = 0;
    while ((da == 0 || db == 0) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rf_a.init_done && da == 0) begin
        da = cyc;
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
      end
      if (rf_b.init_done && db == 0) begin
        db = cyc;
        drive_b(1'b0, '0, '0, 1'b0, '0, '0);
      end
    end
    exp_q.push_back(DW'(32));
    check({tag, "_cycles_a"}, DW'(da));
    exp_q.push_back(DW'(8));
    check({tag, "_cycles_b"}, DW'(db));
    exp_q.push_back(DW'(RF_RUN));
    check({tag, "_state_a"}, DW'(state_a));
    a_run = 1'b1;
    b_run = 1'b1;
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 8; i++)  model_b[i] = '0;
    @(negedge clk);
  endtask

  task automatic check_init_low(input string tag);
    #1;
    exp_q.push_back('0);
    check({tag, "_init_a"}, DW'(rf_a.init_done));
    exp_q.push_back('0);
    check({tag, "_init_b"}, DW'(rf_b.init_done));
  endtask

  task automatic hold_writes_random();
    drive_a(1'b1, AW_A'($urandom_range(0, 31)), $urandom, 1'b1, AW_A'($urandom_range(0, 31)), $urandom);
    drive_b(1'b1, AW_B'($urandom_range(0, 7)),  $urandom, 1'b1, AW_B'($urandom_range(0, 7)),  $urandom);
  endtask

  task automatic read_all_entries(input string tag);
    for (int i = 0; i < 32; i++) begin
      for (int p = 0; p < NR_A; p++) set_ra_a(p, AW_A'(i));
      for (int p = 0; p < NR_B; p++) set_ra_b(p, AW_B'(i % 8));
      check_all(tag);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rf_a.raddr = '0;
    rf_b.raddr = '0;

    // Reset state
    check_init_low("reset");
    check_all("reset_rd");

    // 1: clear after release with writes held active
    @(negedge clk);
    rst_n = 1'b1;
    hold_writes_random();
    wait_init("init1");
    read_all_entries("cleared1");

    // 2: single write to 5, read on port 2
    drive_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    drive_b(1'b1, 3'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    set_ra_a(2, 5'd5);
    set_ra_b(2, 3'd5);
    check_all("t2_same");
    tick();
    idle();
    check_all("t2_next");

    // 3: dual write same address, port 1 wins; all ports on the same address
    drive_a(1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222);
    drive_b(1'b1, 3'd7, 32'h1111, 1'b1, 3'd7, 32'h2222);
    for (int p = 0; p < NR_A; p++) set_ra_a(p, 5'd7);
    for (int p = 0; p < NR_B; p++) set_ra_b(p, 3'd7);
    check_all("t3_same");
    tick();
    idle();
    check_all("t3_next");

    // 4: writes to address 0 (dropped on A, ordinary on B)
    drive_a(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 32'hFFFF_FFFF);
    drive_b(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 32'hFFFF_FFFF);
    for (int p = 0; p < NR_A; p++) set_ra_a(p, 5'd0);
    for (int p = 0; p < NR_B; p++) set_ra_b(p, 3'd0);
    check_all("t4_same");
    tick();
    idle();
    check_all("t4_next");

    // Random traffic on both instances, distinct and colliding addresses
    for (int n = 0; n < 60; n++) begin
      drive_a($urandom_range(0, 1) == 1, AW_A'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) == 1, AW_A'($urandom_range(0, 31)), $urandom);
      drive_b($urandom_range(0, 1) == 1, AW_B'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, AW_B'($urandom_range(0, 7)), $urandom);
      for (int p = 0; p < NR_A; p++) set_ra_a(p, AW_A'($urandom_range(0, 31)));
      for (int p = 0; p < NR_B; p++) set_ra_b(p, AW_B'($urandom_range(0, 7)));
      check_all("rand");
      tick();
    end
    idle();

    // 5: fill with index, then reset mid-run with writes in flight
    for (int i = 1; i < 32; i++) begin
      drive_a(1'b1, AW_A'(i), DW'(i), 1'b0, '0, '0);
      if (i < 8) drive_b(1'b1, AW_B'(i), DW'(i + 100), 1'b0, '0, '0);
      else       drive_b(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
    end
    idle();
    read_all_entries("filled");

    drive_a(1'b1, 5'd9, 32'hAAAA_AAAA, 1'b1, 5'd10, 32'hBBBB_BBBB);
    drive_b(1'b1, 3'd1, 32'hAAAA_AAAA, 1'b1, 3'd2,  32'hBBBB_BBBB);
    set_ra_a(0, 5'd9);
    set_ra_a(1, 5'd10);
    set_ra_a(2, 5'd3);
    rst_n = 1'b0;
    a_run = 1'b0;
    b_run = 1'b0;
    check_init_low("midrun");
    check_all("midrun_rd");
    tick();
    idle();

    // Mid-clear reset: 10 cycles into the clear
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check_init_low("midclear");
    check_all("midclear_rd");
    tick();
    rst_n = 1'b1;
    hold_writes_random();
    wait_init("init2");
    read_all_entries("cleared2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
